// File: rtl/ttt_turn_sequencer_if.sv
// Request/board/status bundle between the turn sequencer and the board datapath.
interface ttt_turn_sequencer_if;
  logic        play;
  logic        pc;
  logic [3:0]  player_position;
  logic [3:0]  computer_position;
  logic [17:0] board;
  logic [1:0]  who;
  logic [8:0]  wr_en;
  logic [1:0]  wr_code;
  logic [1:0]  turn;
  logic        illegal_move;
  logic        timeout;
  logic        game_over;
  logic        no_space;
  logic [3:0]  move_count;

  modport slave (
    input  play, pc, player_position, computer_position, board, who,
    output wr_en, wr_code, turn, illegal_move, timeout, game_over, no_space, move_count
  );

  modport master (
    output play, pc, player_position, computer_position, board, who,
    input  wr_en, wr_code, turn, illegal_move, timeout, game_over, no_space, move_count
  );
endinterface

// File: rtl/ttt_turn_sequencer.sv
// Tic-tac-toe turn controller: validates moves, strobes board writes, tracks
// the player timeout and latches the end-of-game condition.
module ttt_turn_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 1000,
  parameter int unsigned CNT_W          = 10,
  parameter bit          FIRST_MOVER    = 1'b0
) (
  input  logic               clock,
  input  logic               reset,
  ttt_turn_sequencer_if.slave bus
);

  localparam int unsigned CELLS     = 9;
  localparam logic [1:0] CODE_NONE   = 2'b00;
  localparam logic [1:0] CODE_PLAYER = 2'b01;
  localparam logic [1:0] CODE_PC     = 2'b10;
  localparam logic [3:0] MAX_MOVES   = 4'd9;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PLAYER = 3'd1,
    PC     = 3'd2,
    WRITE  = 3'd3,
    SETTLE = 3'd4,
    DONE   = 3'd5
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   timer_q, timer_d;
  logic [8:0]         wr_en_q, wr_en_d;
  logic [1:0]         wr_code_q, wr_code_d;
  logic [1:0]         turn_q, turn_d;
  logic               illegal_q, illegal_d;
  logic               timeout_q, timeout_d;
  logic               game_over_q, game_over_d;
  logic               no_space_q, no_space_d;
  logic [3:0]         move_count_q, move_count_d;
  logic               play_legal, pc_legal, timer_expired;

  // A request is legal only for cells 1..9 that are still empty.
  function automatic logic cell_legal(input logic [3:0] pos, input logic [17:0] b);
    logic ok;
    ok = 1'b0;
    for (int unsigned k = 1; k <= CELLS; k++) begin
      if (pos == 4'(k) && b[2*k-2 +: 2] == CODE_NONE) ok = 1'b1;
    end
    return ok;
  endfunction

  function automatic logic [8:0] cell_onehot(input logic [3:0] pos);
    logic [8:0] oh;
    oh = '0;
    for (int unsigned k = 1; k <= CELLS; k++) begin
      if (pos == 4'(k)) oh[k-1] = 1'b1;
    end
    return oh;
  endfunction

  assign play_legal    = cell_legal(bus.player_position, bus.board);
  assign pc_legal      = cell_legal(bus.computer_position, bus.board);
  assign timer_expired = (timer_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // State and registered outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      timer_q      <= '0;
      wr_en_q      <= '0;
      wr_code_q    <= CODE_NONE;
      turn_q       <= CODE_NONE;
      illegal_q    <= 1'b0;
      timeout_q    <= 1'b0;
      game_over_q  <= 1'b0;
      no_space_q   <= 1'b0;
      move_count_q <= '0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      wr_en_q      <= wr_en_d;
      wr_code_q    <= wr_code_d;
      turn_q       <= turn_d;
      illegal_q    <= illegal_d;
      timeout_q    <= timeout_d;
      game_over_q  <= game_over_d;
      no_space_q   <= no_space_d;
      move_count_q <= move_count_d;
    end
  end

  // Next-state selection.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = FIRST_MOVER ? PC : PLAYER;
      PLAYER: begin
        if (bus.play && play_legal) state_d = WRITE;
        else if (timer_expired)     state_d = PC;
      end
      PC:      if (bus.pc && pc_legal) state_d = WRITE;
      WRITE:   state_d = SETTLE;
      SETTLE: begin
        if (bus.who != CODE_NONE || move_count_q == MAX_MOVES) state_d = DONE;
        else if (wr_code_q == CODE_PLAYER)                     state_d = PC;
        else                                                   state_d = PLAYER;
      end
      DONE:    state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  // Next output values; they land in the registers alongside the state.
  always_comb begin
    wr_en_d      = '0;
    wr_code_d    = wr_code_q;
    turn_d       = CODE_NONE;
    illegal_d    = 1'b0;
    timeout_d    = 1'b0;
    game_over_d  = game_over_q;
    no_space_d   = no_space_q;
    move_count_d = move_count_q;
    timer_d      = '0;

    case (state_d)
      PLAYER:  turn_d = CODE_PLAYER;
      PC:      turn_d = CODE_PC;
      default: turn_d = CODE_NONE;
    endcase

    case (state_q)
      PLAYER: begin
        if (bus.play && play_legal) begin
          wr_en_d   = cell_onehot(bus.player_position);
          wr_code_d = CODE_PLAYER;
          if (move_count_q < MAX_MOVES) move_count_d = move_count_q + 4'd1;
        end else begin
          illegal_d = bus.play;
          timeout_d = timer_expired;
        end
        if (state_d == PLAYER) timer_d = timer_q + CNT_W'(1);
      end
      PC: begin
        if (bus.pc && pc_legal) begin
          wr_en_d   = cell_onehot(bus.computer_position);
          wr_code_d = CODE_PC;
          if (move_count_q < MAX_MOVES) move_count_d = move_count_q + 4'd1;
        end else begin
          illegal_d = bus.pc;
        end
      end
      SETTLE: begin
        if (bus.who != CODE_NONE)            game_over_d = 1'b1;
        else if (move_count_q == MAX_MOVES)  no_space_d  = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.wr_en        = wr_en_q;
  assign bus.wr_code      = wr_code_q;
  assign bus.turn         = turn_q;
  assign bus.illegal_move = illegal_q;
  assign bus.timeout      = timeout_q;
  assign bus.game_over    = game_over_q;
  assign bus.no_space     = no_space_q;
  assign bus.move_count   = move_count_q;

endmodule

// File: tb/tb_ttt_turn_sequencer.sv
// Directed bench for ttt_turn_sequencer with an 8-cycle player timeout.
module tb_ttt_turn_sequencer;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  always #5 clock = ~clock;

  ttt_turn_sequencer_if bus ();

  ttt_turn_sequencer #(
    .TIMEOUT_CYCLES(8),
    .CNT_W         (4),
    .FIRST_MOVER   (1'b0)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_cell(input int k, input logic [1:0] code);
    bus.board[2*k-2 +: 2] = code;
  endtask

  function automatic logic [8:0] onehot(input int pos);
    logic [8:0] r;
    r = '0;
    r[pos-1] = 1'b1;
    return r;
  endfunction

  task automatic chk_all_clear(input string tag);
    chk({tag, "_wr_en"},      32'(bus.wr_en), 32'h0);
    chk({tag, "_wr_code"},    32'(bus.wr_code), 32'h0);
    chk({tag, "_turn"},       32'(bus.turn), 32'h0);
    chk({tag, "_illegal"},    32'(bus.illegal_move), 32'h0);
    chk({tag, "_timeout"},    32'(bus.timeout), 32'h0);
    chk({tag, "_game_over"},  32'(bus.game_over), 32'h0);
    chk({tag, "_no_space"},   32'(bus.no_space), 32'h0);
    chk({tag, "_move_count"}, 32'(bus.move_count), 32'h0);
  endtask

  // One complete accepted move: request, WRITE, SETTLE, then exit to the next state.
  task automatic do_move(input bit is_player, input int pos, input int exp_count);
    if (is_player) begin bus.play = 1'b1; bus.player_position = 4'(pos); end
    else           begin bus.pc   = 1'b1; bus.computer_position = 4'(pos); end
    step();
    chk("mv_wr_en",   32'(bus.wr_en), 32'(onehot(pos)));
    chk("mv_wr_code", 32'(bus.wr_code), is_player ? 32'h1 : 32'h2);
    chk("mv_count",   32'(bus.move_count), 32'(exp_count));
    bus.play = 1'b0;
    bus.pc   = 1'b0;
    set_cell(pos, is_player ? 2'b01 : 2'b10);
    step();
    chk("mv_settle_wr_en", 32'(bus.wr_en), 32'h0);
    step();
  endtask

  initial begin
    bus.play = 1'b0;
    bus.pc = 1'b0;
    bus.player_position = 4'd0;
    bus.computer_position = 4'd0;
    bus.board = '0;
    bus.who = 2'b00;

    // Reset state
    step();
    step();
    chk_all_clear("rst");
    reset = 1'b1;

    // Test 1: first legal player move
    bus.play = 1'b1;
    bus.player_position = 4'd5;
    step();
    chk("t1_turn_player", 32'(bus.turn), 32'h1);
    chk("t1_idle_wr_en",  32'(bus.wr_en), 32'h0);
    step();
    chk("t1_wr_en",   32'(bus.wr_en), 32'h010);
    chk("t1_wr_code", 32'(bus.wr_code), 32'h1);
    chk("t1_count",   32'(bus.move_count), 32'h1);
    chk("t1_turn_w",  32'(bus.turn), 32'h0);
    bus.play = 1'b0;
    set_cell(5, 2'b01);
    step();
    chk("t1_settle_wr_en", 32'(bus.wr_en), 32'h0);
    chk("t1_settle_code",  32'(bus.wr_code), 32'h1);
    step();
    chk("t1_turn_pc", 32'(bus.turn), 32'h2);

    // Computer move at 7, play input ignored while in PC
    bus.play = 1'b1;
    bus.player_position = 4'd2;
    bus.pc = 1'b1;
    bus.computer_position = 4'd7;
    step();
    chk("pc1_wr_en",   32'(bus.wr_en), 32'h040);
    chk("pc1_wr_code", 32'(bus.wr_code), 32'h2);
    chk("pc1_count",   32'(bus.move_count), 32'h2);
    bus.play = 1'b0;
    bus.pc = 1'b0;
    set_cell(7, 2'b10);
    step();
    step();
    chk("pc1_turn_player", 32'(bus.turn), 32'h1);

    // Test 2: illegal requests (occupied, 0, 12, 10); timer keeps running
    bus.play = 1'b1;
    bus.player_position = 4'd5;
    step();
    chk("t2_ill_occ",   32'(bus.illegal_move), 32'h1);
    chk("t2_wr_en_occ", 32'(bus.wr_en), 32'h0);
    bus.player_position = 4'd0;
    step();
    chk("t2_ill_zero", 32'(bus.illegal_move), 32'h1);
    bus.player_position = 4'd12;
    step();
    chk("t2_ill_12",   32'(bus.illegal_move), 32'h1);
    chk("t2_turn_12",  32'(bus.turn), 32'h1);
    bus.player_position = 4'd10;
    step();
    chk("t2_ill_10",   32'(bus.illegal_move), 32'h1);
    chk("t2_wr_en_10", 32'(bus.wr_en), 32'h0);
    bus.play = 1'b0;
    step();
    chk("t2_ill_drop", 32'(bus.illegal_move), 32'h0);

    // Test 3: timeout after 8 PLAYER cycles in total
    step();
    chk("t3_no_to_6", 32'(bus.timeout), 32'h0);
    step();
    chk("t3_no_to_7", 32'(bus.timeout), 32'h0);
    chk("t3_turn_7",  32'(bus.turn), 32'h1);
    step();
    chk("t3_timeout", 32'(bus.timeout), 32'h1);
    chk("t3_turn_pc", 32'(bus.turn), 32'h2);
    bus.play = 1'b1;
    bus.player_position = 4'd9;
    step();
    chk("t3_to_drop",     32'(bus.timeout), 32'h0);
    chk("t3_play_ign",    32'(bus.wr_en), 32'h0);
    chk("t3_turn_hold",   32'(bus.turn), 32'h2);
    bus.play = 1'b0;
    bus.pc = 1'b1;
    bus.computer_position = 4'd7;
    step();
    chk("t3_pc_illegal", 32'(bus.illegal_move), 32'h1);
    bus.computer_position = 4'd1;
    step();
    chk("t3_wr_en",   32'(bus.wr_en), 32'h001);
    chk("t3_wr_code", 32'(bus.wr_code), 32'h2);
    chk("t3_count",   32'(bus.move_count), 32'h3);
    bus.pc = 1'b0;
    set_cell(1, 2'b10);
    step();
    step();
    chk("t3_turn_player", 32'(bus.turn), 32'h1);

    // Test 4: legal play on the expiry cycle wins over the timeout
    for (int i = 0; i < 7; i++) step();
    chk("t4_pre_timeout", 32'(bus.timeout), 32'h0);
    bus.play = 1'b1;
    bus.player_position = 4'd2;
    step();
    chk("t4_wr_en",    32'(bus.wr_en), 32'h002);
    chk("t4_wr_code",  32'(bus.wr_code), 32'h1);
    chk("t4_timeout",  32'(bus.timeout), 32'h0);
    chk("t4_count",    32'(bus.move_count), 32'h4);
    bus.play = 1'b0;
    set_cell(2, 2'b01);
    step();
    chk("t4_timeout_settle", 32'(bus.timeout), 32'h0);
    step();
    chk("t4_turn_pc", 32'(bus.turn), 32'h2);

    // Test 5: winner reported during SETTLE of the 5th move
    bus.pc = 1'b1;
    bus.computer_position = 4'd3;
    step();
    chk("t5_wr_en", 32'(bus.wr_en), 32'h004);
    chk("t5_count", 32'(bus.move_count), 32'h5);
    bus.pc = 1'b0;
    set_cell(3, 2'b10);
    step();
    bus.who = 2'b01;
    step();
    chk("t5_game_over", 32'(bus.game_over), 32'h1);
    chk("t5_turn",      32'(bus.turn), 32'h0);
    chk("t5_no_space",  32'(bus.no_space), 32'h0);
    bus.play = 1'b1;
    bus.player_position = 4'd9;
    bus.pc = 1'b1;
    bus.computer_position = 4'd8;
    step();
    step();
    chk("t5_done_wr_en", 32'(bus.wr_en), 32'h0);
    chk("t5_done_hold",  32'(bus.game_over), 32'h1);
    chk("t5_done_count", 32'(bus.move_count), 32'h5);
    chk("t5_done_ill",   32'(bus.illegal_move), 32'h0);
    #2;
    reset = 1'b0;
    #1;
    chk_all_clear("t5_async_rst");

    // Test 6: nine moves without a winner fill the board
    bus.play = 1'b0;
    bus.pc = 1'b0;
    bus.who = 2'b00;
    bus.board = '0;
    step();
    reset = 1'b1;
    step();
    chk("t6_turn_start", 32'(bus.turn), 32'h1);
    do_move(1'b1, 1, 1);
    do_move(1'b0, 2, 2);
    do_move(1'b1, 3, 3);
    do_move(1'b0, 5, 4);
    do_move(1'b1, 4, 5);
    do_move(1'b0, 6, 6);
    do_move(1'b1, 8, 7);
    chk("t6_turn_mid", 32'(bus.turn), 32'h2);
    do_move(1'b0, 7, 8);
    do_move(1'b1, 9, 9);
    chk("t6_no_space",  32'(bus.no_space), 32'h1);
    chk("t6_game_over", 32'(bus.game_over), 32'h0);
    chk("t6_count",     32'(bus.move_count), 32'h9);
    chk("t6_turn",      32'(bus.turn), 32'h0);
    step();
    chk("t6_no_space_hold", 32'(bus.no_space), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ttt_turn_sequencer.md
Name: ttt_turn_sequencer

Overview:
Turn controller for the tic-tac-toe board datapath. It decides whose move is accepted, validates the requested position against the current board, and issues one-cycle write strobes to the board registers. It then waits for the win detector and stops the game on a win or a full board. It also enforces a player move timeout that hands the turn to the computer.

Parameters:
TIMEOUT_CYCLES, 1000, cycles the player may hold the turn before it passes to the computer (must be >= 2)
CNT_W, 10, width of the timeout counter (must satisfy 2^CNT_W >= TIMEOUT_CYCLES)
FIRST_MOVER, 0, 0 = player moves first after reset, 1 = computer moves first

Ports:
clock  input  1  game clock; all state updates on rising edge
reset  input  1  asynchronous, active-low; 0 clears all state immediately
play  input  1  player move request, level sampled each clock
pc  input  1  computer move request, level sampled each clock
player_position  input  4  requested cell, 1..9
computer_position  input  4  requested cell, 1..9
board  input  18  current cell codes from the board datapath; cell k (1..9) at [2k-1:2k-2]; 00 empty, 01 player, 10 computer
who  input  2  winner from the datapath: 00 none, 01 player, 10 computer
wr_en  output  9  one-hot cell write strobe; bit k-1 = cell k
wr_code  output  2  code to write: 01 player, 10 computer
turn  output  2  01 player turn, 10 computer turn, 00 none
illegal_move  output  1  one-cycle pulse on a rejected request
timeout  output  1  one-cycle pulse when the player turn expires
game_over  output  1  high once a winner is detected, held until reset
no_space  output  1  high when 9 moves are made with no winner, held until reset
move_count  output  4  accepted moves, 0..9

Behaviour:
- All outputs are registered.
- Reset values: wr_en 0, wr_code 00, turn 00, illegal_move 0, timeout 0, game_over 0, no_space 0, move_count 0, timer 0, state IDLE.
- A reset asserted mid-operation aborts any in-flight wr_en immediately.
- Legal request: position in 1..9 AND board cell == 00.
- Illegal request: position 0, position 10..15, or an occupied cell.
- States:
  - IDLE: a single cycle after reset deassertion. Goes to PLAYER if FIRST_MOVER=0, else to PC. turn=00.
  - PLAYER: turn=01, timer increments every cycle.
    - play=1 and legal: go to WRITE with wr_code=01. wr_en is high in the cycle after sampling (latency 1).
    - play=1 and illegal: illegal_move=1 for 1 cycle. Stay in PLAYER; the timer is NOT cleared.
    - Timer == TIMEOUT_CYCLES-1 with no legal play: timeout=1 for 1 cycle, clear timer, go to PC.
    - Legal play in the same cycle as the timeout: the play wins and no timeout pulse is issued.
    - The pc input is ignored in this state.
  - PC: turn=10, no timeout.
    - pc=1 and legal: go to WRITE with wr_code=10.
    - pc=1 and illegal: illegal_move pulse, stay in PC.
    - The play input is ignored in this state.
  - WRITE: wr_en is one-hot for exactly 1 cycle, move_count increments, timer clears, turn=00. Go to SETTLE.
  - SETTLE: 1 cycle with wr_en=0, allowing board and who to update. On exit:
    - who != 00: go to DONE, game_over=1.
    - Else move_count == 9: go to DONE, no_space=1.
    - Else: go to the opposite turn of the last writer.
  - DONE: turn=00, wr_en=0. play and pc are ignored. Held until reset.
- Outside WRITE, wr_en is 0 and wr_code holds its last value.
- When play and pc are high together, only the request for the current turn is considered.
- Requests are level sampled: a play held high across WRITE/SETTLE is re-evaluated only when the state is next PLAYER. A held request on an already-occupied cell then produces illegal_move.
- move_count saturates at 9; it cannot exceed 9 because DONE is entered.
- The timer wraps never: it is cleared on timeout or on WRITE.

Test Plan:
1. Release reset with FIRST_MOVER=0, then play=1, player_position=5, board all 00 -> turn=01 in PLAYER; next cycle wr_en=9'b000010000, wr_code=01, move_count=1; 2 cycles later turn=10.
2. In PLAYER, board cell 5=01, play=1, player_position=5, then position 0, then position 12 -> illegal_move pulses each cycle, wr_en stays 0, turn stays 01.
3. TIMEOUT_CYCLES=8, hold play=0 in PLAYER -> timeout pulses on the 8th PLAYER cycle, turn=10 next cycle; play in PC ignored; pc=1, computer_position=1 -> wr_en=9'b000000001, wr_code=10.
4. Legal play on the exact cycle the timer expires -> WRITE with wr_code=01, no timeout pulse.
5. Drive who=01 during the SETTLE after the 5th move -> game_over=1, turn=00; further play/pc give no wr_en; reset=0 mid-DONE clears all outputs asynchronously.
6. Nine legal alternating moves with who=00 -> after the 9th WRITE/SETTLE, no_space=1, game_over=0, move_count=9, turn=00.
